// File: rtl/peripheral_msi_slave_port_bb.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_msi_slave_port_bb
// Brief    : Slave-side port of an AHB-Lite multi-layer interconnect. Picks one
//            master by 3-bit priority (ties: round-robin when the macro
//            PERIPHERAL_MSI_SLAVE_ROUND_ROBIN_EN is defined, else lowest
//            index), drives its address phase to the slave, muxes write data
//            by the registered data-phase owner and broadcasts the response.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_msi_slave_port_bb #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
) (
    input  logic                          HCLK,
    input  logic                          HRESET,

    input  logic [MASTERS-1:0][2:0]       mstpriority,
    input  logic [MASTERS-1:0]            mstHSEL,
    input  logic [MASTERS-1:0][PLEN-1:0]  mstHADDR,
    input  logic [MASTERS-1:0][XLEN-1:0]  mstHWDATA,
    input  logic [MASTERS-1:0]            mstHWRITE,
    input  logic [MASTERS-1:0][2:0]       mstHSIZE,
    input  logic [MASTERS-1:0][2:0]       mstHBURST,
    input  logic [MASTERS-1:0][3:0]       mstHPROT,
    input  logic [MASTERS-1:0][1:0]       mstHTRANS,
    input  logic [MASTERS-1:0]            mstHMASTLOCK,
    input  logic [MASTERS-1:0]            mstHREADY,
    input  logic [MASTERS-1:0]            can_switch,

    output logic [MASTERS-1:0]            master_granted,
    output logic [XLEN-1:0]               mstHRDATA,
    output logic                          mstHREADYOUT,
    output logic                          mstHRESP,

    output logic                          slv_HSEL,
    output logic [PLEN-1:0]               slv_HADDR,
    output logic [XLEN-1:0]               slv_HWDATA,
    output logic                          slv_HWRITE,
    output logic [2:0]                    slv_HSIZE,
    output logic [2:0]                    slv_HBURST,
    output logic [3:0]                    slv_HPROT,
    output logic [1:0]                    slv_HTRANS,
    output logic                          slv_HMASTLOCK,
    output logic                          slv_HREADY,

    input  logic [XLEN-1:0]               slv_HRDATA,
    input  logic                          slv_HREADYOUT,
    input  logic                          slv_HRESP
);

    localparam int         c_IW       = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [1:0] c_HTRANS_IDLE = 2'b00;

    logic [MASTERS-1:0] r_granted;
    logic [c_IW-1:0]    r_gidx;
    logic [c_IW-1:0]    r_owner;

    logic               w_has_grant;
    logic               w_switch_ok;
    logic               w_any_req;
    logic [2:0]         w_max_prio;
    logic [c_IW-1:0]    w_win;
    logic [MASTERS-1:0] w_win_oh;

    assign w_has_grant = |r_granted;
    assign w_any_req   = |mstHSEL;
    assign w_switch_ok = (!w_has_grant || can_switch[r_gidx]) && slv_HREADYOUT;

    always_comb begin
        w_max_prio = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (mstHSEL[i] && (mstpriority[i] > w_max_prio)) begin
                w_max_prio = mstpriority[i];
            end
        end
    end

`ifdef PERIPHERAL_MSI_SLAVE_ROUND_ROBIN_EN
    logic [c_IW-1:0] r_last;
    logic            w_found;
    int              w_idx;

    // Scan starts one past the last winner so equal-priority requesters rotate.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= MASTERS; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= MASTERS) begin
                w_idx = w_idx - MASTERS;
            end
            if (!w_found && mstHSEL[w_idx] && (mstpriority[w_idx] == w_max_prio)) begin
                w_found = 1'b1;
                w_win   = c_IW'(w_idx);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_last <= c_IW'(MASTERS - 1);
        end else if (w_switch_ok && w_any_req) begin
            r_last <= w_win;
        end
    end
`else
    // Descending scan leaves the lowest matching index as the winner.
    always_comb begin
        w_win = '0;
        for (int i = MASTERS - 1; i >= 0; i--) begin
            if (mstHSEL[i] && (mstpriority[i] == w_max_prio)) begin
                w_win = c_IW'(i);
            end
        end
    end
`endif

    always_comb begin
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
    end

    // With no requesters the grant parks on whoever held it last.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_granted <= '0;
            r_gidx    <= '0;
        end else if (w_switch_ok && w_any_req) begin
            r_granted <= w_win_oh;
            r_gidx    <= w_win;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_owner <= '0;
        end else if (slv_HREADY && slv_HREADYOUT) begin
            r_owner <= r_gidx;
        end
    end

    assign master_granted = r_granted;

    assign slv_HSEL      = mstHSEL[r_gidx] & w_has_grant;
    assign slv_HTRANS    = slv_HSEL ? mstHTRANS[r_gidx] : c_HTRANS_IDLE;
    assign slv_HADDR     = mstHADDR[r_gidx];
    assign slv_HWRITE    = mstHWRITE[r_gidx];
    assign slv_HSIZE     = mstHSIZE[r_gidx];
    assign slv_HBURST    = mstHBURST[r_gidx];
    assign slv_HPROT     = mstHPROT[r_gidx];
    assign slv_HMASTLOCK = mstHMASTLOCK[r_gidx];
    assign slv_HREADY    = w_has_grant ? mstHREADY[r_gidx] : slv_HREADYOUT;

    assign slv_HWDATA    = mstHWDATA[r_owner];

    assign mstHRDATA     = slv_HRDATA;
    assign mstHREADYOUT  = slv_HREADYOUT;
    assign mstHRESP      = slv_HRESP;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_msi_slave_port_bb.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_msi_slave_port_bb
// Brief    : Directed bench with a cycle-level reference model of the slave
//            port and per-cycle comparison of every DUT output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_msi_slave_port_bb;

    localparam int PLEN = 64;
    localparam int XLEN = 64;
    localparam int M    = 5;

    logic                    HCLK = 1'b0;
    logic                    HRESET = 1'b0;
    logic [M-1:0][2:0]       mstpriority;
    logic [M-1:0]            mstHSEL;
    logic [M-1:0][PLEN-1:0]  mstHADDR;
    logic [M-1:0][XLEN-1:0]  mstHWDATA;
    logic [M-1:0]            mstHWRITE;
    logic [M-1:0][2:0]       mstHSIZE;
    logic [M-1:0][2:0]       mstHBURST;
    logic [M-1:0][3:0]       mstHPROT;
    logic [M-1:0][1:0]       mstHTRANS;
    logic [M-1:0]            mstHMASTLOCK;
    logic [M-1:0]            mstHREADY;
    logic [M-1:0]            can_switch;
    logic [M-1:0]            master_granted;
    logic [XLEN-1:0]         mstHRDATA;
    logic                    mstHREADYOUT;
    logic                    mstHRESP;
    logic                    slv_HSEL;
    logic [PLEN-1:0]         slv_HADDR;
    logic [XLEN-1:0]         slv_HWDATA;
    logic                    slv_HWRITE;
    logic [2:0]              slv_HSIZE;
    logic [2:0]              slv_HBURST;
    logic [3:0]              slv_HPROT;
    logic [1:0]              slv_HTRANS;
    logic                    slv_HMASTLOCK;
    logic                    slv_HREADY;
    logic [XLEN-1:0]         slv_HRDATA;
    logic                    slv_HREADYOUT;
    logic                    slv_HRESP;

    peripheral_msi_slave_port_bb #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(M)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .mstpriority(mstpriority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR),
        .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE),
        .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY), .can_switch(can_switch),
        .master_granted(master_granted), .mstHRDATA(mstHRDATA),
        .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
        .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
        .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
        .slv_HREADY(slv_HREADY), .slv_HRDATA(slv_HRDATA),
        .slv_HREADYOUT(slv_HREADYOUT), .slv_HRESP(slv_HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference model: granted master (-1 = none), tie pointer, data owner.
    int m_g   = -1;
    int m_ptr = M - 1;
    int m_own = 0;
    int m_win;

    function automatic int pick();
        int best = -1;
        int bp   = -1;
`ifdef PERIPHERAL_MSI_SLAVE_ROUND_ROBIN_EN
        for (int k = 1; k <= M; k++) begin
            int i = (m_ptr + k) % M;
            if (mstHSEL[i] && int'(mstpriority[i]) > bp) begin
                bp = int'(mstpriority[i]);
                best = i;
            end
        end
`else
        for (int i = 0; i < M; i++) begin
            if (mstHSEL[i] && int'(mstpriority[i]) > bp) begin
                bp = int'(mstpriority[i]);
                best = i;
            end
        end
`endif
        return best;
    endfunction

    function automatic logic exp_hready();
        return (m_g >= 0) ? mstHREADY[m_g] : slv_HREADYOUT;
    endfunction

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            m_g   <= -1;
            m_ptr <= M - 1;
            m_own <= 0;
        end else begin
            m_win = pick();
            if (exp_hready() && slv_HREADYOUT) m_own <= (m_g < 0) ? 0 : m_g;
            if ((m_g < 0 || can_switch[m_g]) && slv_HREADYOUT && m_win >= 0) begin
                m_g   <= m_win;
                m_ptr <= m_win;
            end
        end
    end

    always @(negedge HCLK) begin
        int g;
        logic [M-1:0] eg;
        logic ehsel;
        g  = (m_g < 0) ? 0 : m_g;
        eg = '0;
        if (m_g >= 0) eg[m_g] = 1'b1;
        ehsel = (m_g >= 0) && mstHSEL[g];
        chk("cyc_granted",  64'(master_granted), 64'(eg));
        chk("cyc_hsel",     64'(slv_HSEL),       64'(ehsel));
        chk("cyc_htrans",   64'(slv_HTRANS),     ehsel ? 64'(mstHTRANS[g]) : 64'd0);
        chk("cyc_haddr",    slv_HADDR,           mstHADDR[g]);
        chk("cyc_hctrl",    {52'd0, slv_HWRITE, slv_HSIZE, slv_HBURST, slv_HPROT, slv_HMASTLOCK},
                            {52'd0, mstHWRITE[g], mstHSIZE[g], mstHBURST[g], mstHPROT[g], mstHMASTLOCK[g]});
        chk("cyc_hready",   64'(slv_HREADY),     64'(exp_hready()));
        chk("cyc_hwdata",   slv_HWDATA,          mstHWDATA[m_own]);
        chk("cyc_resp",     {62'd0, mstHREADYOUT, mstHRESP}, {62'd0, slv_HREADYOUT, slv_HRESP});
        chk("cyc_hrdata",   mstHRDATA,           slv_HRDATA);
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ready_all(input logic r);
        slv_HREADYOUT = r;
        mstHREADY     = {M{r}};
    endtask

    initial begin
        mstpriority  = '0;
        mstHSEL      = '0;
        mstHWRITE    = '0;
        mstHSIZE     = '0;
        mstHBURST    = '0;
        mstHPROT     = '0;
        mstHMASTLOCK = '0;
        mstHTRANS    = '0;
        can_switch   = {M{1'b1}};
        slv_HRDATA   = 64'h0;
        slv_HRESP    = 1'b0;
        ready_all(1'b1);
        for (int i = 0; i < M; i++) begin
            mstHADDR[i]  = 64'h1000_0000 * 64'(i + 1) + 64'h40;
            mstHWDATA[i] = 64'hDA7A_0000_0000_0000 | 64'(i * 16 + 7);
            mstHSIZE[i]  = 3'(i % 4);
            mstHPROT[i]  = 4'(i + 3);
            mstHTRANS[i] = 2'b10;
        end
        #1 HRESET = 1'b1;
        tick(); tick();
        chk("rst_granted", 64'(master_granted), 64'd0);
        chk("rst_htrans",  64'(slv_HTRANS),     64'd0);
        chk("rst_hready",  64'(slv_HREADY),     64'd1);
        HRESET = 1'b0;
        tick();

        // Masters 1 (prio 3) and 3 (prio 5)
        mstpriority[1] = 3'd3; mstpriority[3] = 3'd5;
        mstHSEL = 5'b01010;
        tick();
        chk("prio_granted", 64'(master_granted), 64'h08);
        chk("prio_haddr",   slv_HADDR, mstHADDR[3]);
        mstHSEL = '0;
        tick();

        // Reset mid-transfer with master 2 granted
        mstpriority = '0;
        mstHSEL = 5'b00100;
        tick();
        chk("m2_granted", 64'(master_granted), 64'h04);
        HRESET = 1'b1;
        #1;
        chk("rstmid_granted", 64'(master_granted), 64'd0);
        chk("rstmid_htrans",  64'(slv_HTRANS),     64'd0);
        chk("rstmid_hready",  64'(slv_HREADY),     64'd1);
        mstHSEL = '0;
        tick();
        HRESET = 1'b0;
        tick(); tick();
        chk("rstidle_granted", 64'(master_granted), 64'd0);

        // Equal-priority tie among 0,2,4
        mstpriority[0] = 3'd2; mstpriority[2] = 3'd2; mstpriority[4] = 3'd2;
        mstHSEL = 5'b10101;
        begin
            logic [M-1:0] exp_seq [4];
`ifdef PERIPHERAL_MSI_SLAVE_ROUND_ROBIN_EN
            exp_seq = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
`else
            exp_seq = '{5'b00001, 5'b00001, 5'b00001, 5'b00001};
`endif
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("tie_granted", 64'(master_granted), 64'(exp_seq[k]));
            end
        end

        // Burst hold on master 1 while master 4 asks at prio 7
        mstpriority = '0;
        mstpriority[1] = 3'd1;
        mstHSEL = 5'b00010;
        tick();
        chk("burst_start", 64'(master_granted), 64'h02);
        can_switch[1] = 1'b0;
        mstHBURST[1] = 3'b011;
        mstHTRANS[1] = 2'b11;
        mstpriority[4] = 3'd7;
        mstHSEL = 5'b10010;
        tick(); tick();
        chk("burst_hold", 64'(master_granted), 64'h02);
        mstHSEL[1] = 1'b0;
        #1;
        chk("drop_htrans", 64'(slv_HTRANS), 64'd0);
        chk("drop_hsel",   64'(slv_HSEL),   64'd0);
        tick();
        chk("drop_granted", 64'(master_granted), 64'h02);
        mstHSEL[1] = 1'b1;
        tick();
        can_switch[1] = 1'b1;
        tick();
        chk("burst_release", 64'(master_granted), 64'h10);

        // Back-to-back writes, master 0 then master 2, one wait state
        mstpriority = '0;
        mstHTRANS[1] = 2'b10;
        mstHWRITE = 5'b00101;
        mstHSEL = 5'b00001;
        tick();
        chk("wr0_granted", 64'(master_granted), 64'h01);
        mstHSEL = 5'b00100;
        tick();
        chk("wr2_granted", 64'(master_granted), 64'h04);
        ready_all(1'b0);
        #1;
        chk("wait_hwdata0", slv_HWDATA, mstHWDATA[0]);
        tick();
        chk("wait_hwdata0b", slv_HWDATA, mstHWDATA[0]);
        ready_all(1'b1);
        tick();
        chk("wr_hwdata2", slv_HWDATA, mstHWDATA[2]);

        // Error response with a wait cycle; grant must not move
        mstHSEL = 5'b00001;
        mstpriority[0] = 3'd7;
        slv_HRESP = 1'b1;
        ready_all(1'b0);
        #1;
        chk("err_hresp",    64'(mstHRESP),     64'd1);
        chk("err_hreadyo0", 64'(mstHREADYOUT), 64'd0);
        tick();
        chk("err_granted",  64'(master_granted), 64'h04);
        ready_all(1'b1);
        slv_HRDATA = 64'hFEED_BEEF_0123_4567;
        #1;
        chk("err_hreadyo1", 64'(mstHREADYOUT), 64'd1);
        chk("err_hrdata",   mstHRDATA, 64'hFEED_BEEF_0123_4567);
        tick();
        chk("err_after",    64'(master_granted), 64'h01);
        slv_HRESP = 1'b0;
        mstHSEL = '0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
